// File: rtl/me_window_sched.sv
// Search-window sweep sequencer for the 8-column reference-pixel FIFO chain of the ME array.
// Reads WIN_ROWS window rows, feeds the chain and emits skewed per-column valid/row strobes.
module me_window_sched #(
    parameter int BLK_ROWS   = 16,
    parameter int V_CAND     = 8,
    parameter int N_COL      = 8,
    parameter int ROW_W      = 184,
    parameter int ADDR_W     = 5,
    parameter int MEM_LAT    = 1,
    parameter int CHAIN_LAT0 = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [ADDR_W-1:0]    base_addr_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 mem_rd_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    input  logic [ROW_W-1:0]     mem_data_i,
    output logic [ROW_W-1:0]     fifo_data_o,
    output logic [N_COL-1:0]     col_vld_o,
    output logic [N_COL*5-1:0]   col_row_o,
    output logic [1:0]           state_o
);

    localparam int WIN_ROWS = BLK_ROWS + V_CAND - 1;
    localparam int TAPS     = N_COL + CHAIN_LAT0;
    localparam logic [4:0] LAST_ROW = 5'(WIN_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] base_q;
    logic [4:0]        rd_cnt;
    logic              fetch;
    logic              rd_last;
    logic              last_seen;

    logic [MEM_LAT-1:0] pipe_vld;
    logic [4:0]         pipe_row [MEM_LAT];
    logic               pipe_out;

    logic [ROW_W-1:0]   fifo_q;
    logic [TAPS-1:0]    line_vld;
    logic [4:0]         line_row [TAPS];

    assign fetch     = (state == FETCH);
    assign rd_last   = (rd_cnt == LAST_ROW);
    assign pipe_out  = pipe_vld[MEM_LAT-1];
    assign last_seen = line_vld[TAPS-1] && (line_row[TAPS-1] == LAST_ROW);

    // start_i is a one-cycle request with no ready: it is taken only while IDLE,
    // any pulse in another state (including DONE) is dropped, never queued.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i)   state_nxt = FETCH;
            FETCH:   if (rd_last)   state_nxt = DRAIN;
            DRAIN:   if (last_seen) state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            base_q <= '0;
            rd_cnt <= '0;
        end else if (state == IDLE && start_i) begin
            base_q <= base_addr_i;
            rd_cnt <= '0;
        end else if (fetch && !rd_last) begin
            rd_cnt <= rd_cnt + 5'd1;
        end
    end

    // Row index travels with the read-valid bit so the strobes never look at mem_data_i.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pipe_vld <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_row[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= fetch;
            pipe_row[0] <= fetch ? rd_cnt : 5'd0;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_row[i] <= pipe_row[i-1];
            end
        end
    end

    // Tap 0 is aligned with fifo_data_o; tap CHAIN_LAT0+k with chain column k.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fifo_q   <= '0;
            line_vld <= '0;
            for (int i = 0; i < TAPS; i++) begin
                line_row[i] <= '0;
            end
        end else begin
            fifo_q      <= pipe_out ? mem_data_i : '0;
            line_vld[0] <= pipe_out;
            line_row[0] <= pipe_out ? pipe_row[MEM_LAT-1] : 5'd0;
            for (int i = 1; i < TAPS; i++) begin
                line_vld[i] <= line_vld[i-1];
                line_row[i] <= line_row[i-1];
            end
        end
    end

    always_comb begin
        col_vld_o = '0;
        col_row_o = '0;
        for (int k = 0; k < N_COL; k++) begin
            col_vld_o[k]       = line_vld[CHAIN_LAT0+k];
            col_row_o[5*k +: 5] = line_row[CHAIN_LAT0+k];
        end
    end

    assign busy_o      = (state != IDLE);
    assign done_o      = (state == DONE);
    assign mem_rd_o    = fetch;
    assign mem_addr_o  = fetch ? (base_q + ADDR_W'(rd_cnt)) : '0;
    assign fifo_data_o = fifo_q;
    assign state_o     = state;

endmodule

// File: tb/tb_me_window_sched.sv
// Bench for me_window_sched: two instances (MEM_LAT 1 and 3) checked every cycle against
// a timing model derived from the sweep rules, plus table-driven and hand-written sequences.
module tb_me_window_sched;

    localparam int ROW_W = 184;
    localparam int N_COL = 8;
    localparam int WIN   = 23;
    localparam int CL0   = 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] base  = 5'd0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic             busy   [2];
    logic             done   [2];
    logic             mem_rd [2];
    logic [4:0]       addr   [2];
    logic [ROW_W-1:0] mdata  [2];
    logic [ROW_W-1:0] fifo   [2];
    logic [7:0]       cvld   [2];
    logic [39:0]      crow   [2];
    logic [1:0]       st     [2];

    logic [ROW_W-1:0] mem [32];

    function automatic logic [ROW_W-1:0] rand_row();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[ROW_W-1:0];
    endfunction

    genvar g;
    for (g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : 3;
        logic             pv [4] = '{default: 1'b0};
        logic [4:0]       pa [4] = '{default: 5'd0};
        logic [ROW_W-1:0] junk = '0;

        // Window SRAM model: garbage on the bus whenever no read is landing.
        always @(posedge clk) begin
            pv[0] <= mem_rd[g];
            pa[0] <= addr[g];
            for (int i = 1; i < 4; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
            junk <= rand_row();
        end
        assign mdata[g] = pv[L-1] ? mem[pa[L-1]] : junk;

        me_window_sched #(.MEM_LAT(L)) u_dut (
            .clk_i       (clk),
            .rst_i       (rst_n),
            .start_i     (start),
            .base_addr_i (base),
            .busy_o      (busy[g]),
            .done_o      (done[g]),
            .mem_rd_o    (mem_rd[g]),
            .mem_addr_o  (addr[g]),
            .mem_data_i  (mdata[g]),
            .fifo_data_o (fifo[g]),
            .col_vld_o   (cvld[g]),
            .col_row_o   (crow[g]),
            .state_o     (st[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input int u, input logic [191:0] a, input logic [191:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, u, cyc, a, e);
        end
    endtask

    // Reference model: one active sweep per instance, described by its first fetch cycle.
    int         lat [2] = '{1, 3};
    bit         act [2] = '{1'b0, 1'b0};
    int         c0  [2] = '{0, 0};
    logic [4:0] mb  [2] = '{5'd0, 5'd0};

    // Observations used by the scenario tables.
    int         reads_seen [2];
    int         done_cnt   [2];
    int         done_cyc   [2];
    bit         first_seen [2];
    logic [4:0] first_addr [2];
    logic [4:0] last_addr  [2];

    task automatic clear_meas();
        for (int u = 0; u < 2; u++) begin
            reads_seen[u] = 0;
            done_cnt[u]   = 0;
            done_cyc[u]   = -1;
            first_seen[u] = 1'b0;
            first_addr[u] = 5'd0;
            last_addr[u]  = 5'd0;
        end
    endtask

    task automatic check_dut(input int u);
        int               n;
        int               d;
        int               dd;
        int               r;
        logic             e_busy;
        logic             e_done;
        logic             e_rd;
        logic [4:0]       e_addr;
        logic [ROW_W-1:0] e_fifo;
        logic [7:0]       e_cv;
        logic [39:0]      e_cr;
        n      = cyc;
        d      = 0;
        dd     = WIN + lat[u] + CL0 + N_COL;
        e_busy = 1'b0;
        e_done = 1'b0;
        e_rd   = 1'b0;
        e_addr = 5'd0;
        e_fifo = '0;
        e_cv   = 8'd0;
        e_cr   = 40'd0;
        if (rst_n && act[u]) begin
            d      = n - c0[u];
            e_busy = (d >= 0) && (d <= dd);
            e_done = (d == dd);
            e_rd   = (d >= 0) && (d < WIN);
            if (e_rd) e_addr = 5'((int'(mb[u]) + d) & 31);
            r = d - lat[u] - 1;
            if (r >= 0 && r < WIN) e_fifo = mem[(int'(mb[u]) + r) & 31];
            for (int k = 0; k < N_COL; k++) begin
                r = d - lat[u] - 1 - CL0 - k;
                if (r >= 0 && r < WIN) begin
                    e_cv[k]       = 1'b1;
                    e_cr[5*k +: 5] = 5'(r);
                end
            end
        end
        check("busy",    u, 192'(busy[u]),   192'(e_busy));
        check("done",    u, 192'(done[u]),   192'(e_done));
        check("mem_rd",  u, 192'(mem_rd[u]), 192'(e_rd));
        check("addr",    u, 192'(addr[u]),   192'(e_addr));
        check("fifo",    u, 192'(fifo[u]),   192'(e_fifo));
        check("col_vld", u, 192'(cvld[u]),   192'(e_cv));
        check("col_row", u, 192'(crow[u]),   192'(e_cr));

        if (!rst_n) begin
            act[u] = 1'b0;
        end else begin
            if (act[u] && d >= dd) act[u] = 1'b0;
            if (!e_busy && start) begin
                act[u] = 1'b1;
                c0[u]  = n + 1;
                mb[u]  = base;
            end
            if (mem_rd[u]) begin
                reads_seen[u]++;
                if (!first_seen[u]) begin
                    first_seen[u] = 1'b1;
                    first_addr[u] = addr[u];
                end
                last_addr[u] = addr[u];
            end
            if (done[u]) begin
                done_cnt[u]++;
                done_cyc[u] = n;
            end
        end
    endtask

    always @(negedge clk) begin
        check_dut(0);
        check_dut(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy[0] && !busy[1] && done_cnt[0] > 0 && done_cnt[1] > 0) break;
            tick();
        end
    endtask

    typedef struct {
        logic [4:0] base;
        logic [4:0] exp_first;
        logic [4:0] exp_last;
        int         exp_reads;
        int         exp_lat0;
        int         exp_lat1;
    } vec_t;

    vec_t tbl [4];
    int   s;

    initial begin
        tbl[0] = '{5'h00, 5'h00, 5'h16, 23, 34, 36};
        tbl[1] = '{5'h1C, 5'h1C, 5'h12, 23, 34, 36};
        tbl[2] = '{5'h0A, 5'h0A, 5'h00, 23, 34, 36};
        tbl[3] = '{5'h1F, 5'h1F, 5'h15, 23, 34, 36};
        for (int i = 0; i < 32; i++) mem[i] = rand_row();
        clear_meas();

        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Table-driven sweeps; base is scrambled right after start to prove it was latched.
        for (int i = 0; i < 4; i++) begin
            clear_meas();
            start = 1'b1;
            base  = tbl[i].base;
            s     = cyc;
            tick();
            start = 1'b0;
            base  = 5'($urandom);
            wait_idle(80);
            repeat (2) tick();
            for (int u = 0; u < 2; u++) begin
                check("tbl_reads", u, 192'(reads_seen[u]), 192'(tbl[i].exp_reads));
                check("tbl_first", u, 192'(first_addr[u]), 192'(tbl[i].exp_first));
                check("tbl_last",  u, 192'(last_addr[u]),  192'(tbl[i].exp_last));
                check("tbl_ndone", u, 192'(done_cnt[u]),   192'(1));
                check("tbl_lat",   u, 192'(done_cyc[u] - s),
                      192'((u == 0) ? tbl[i].exp_lat0 : tbl[i].exp_lat1));
            end
        end

        // Starts while busy and during done are dropped; the next IDLE start is taken.
        clear_meas();
        start = 1'b1;
        base  = 5'd3;
        s     = cyc;
        tick();
        start = 1'b0;
        while (cyc < s + 5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < s + 34) tick();
        start = 1'b1;
        tick();
        start = 1'b1;
        base  = 5'd7;
        tick();
        start = 1'b0;
        repeat (60) tick();
        check("ign_ndone", 0, 192'(done_cnt[0]),   192'(2));
        check("ign_ndone", 1, 192'(done_cnt[1]),   192'(1));
        check("ign_reads", 0, 192'(reads_seen[0]), 192'(46));
        check("ign_reads", 1, 192'(reads_seen[1]), 192'(23));

        // Reset mid-sweep aborts immediately; a later start gives a full sweep.
        clear_meas();
        start = 1'b1;
        base  = 5'd9;
        s     = cyc;
        tick();
        start = 1'b0;
        while (cyc < s + 15) tick();
        rst_n = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            check("rst_busy", u, 192'(busy[u]),   192'(0));
            check("rst_rd",   u, 192'(mem_rd[u]), 192'(0));
            check("rst_fifo", u, 192'(fifo[u]),   192'(0));
            check("rst_cvld", u, 192'(cvld[u]),   192'(0));
            check("rst_crow", u, 192'(crow[u]),   192'(0));
        end
        while (cyc < s + 18) tick();
        rst_n = 1'b1;
        while (cyc < s + 20) tick();
        for (int u = 0; u < 2; u++) check("abort_ndone", u, 192'(done_cnt[u]), 192'(0));
        clear_meas();
        start = 1'b1;
        base  = 5'd20;
        s     = cyc;
        tick();
        start = 1'b0;
        wait_idle(80);
        repeat (2) tick();
        for (int u = 0; u < 2; u++) begin
            check("rst_reads", u, 192'(reads_seen[u]), 192'(23));
            check("rst_lat",   u, 192'(done_cyc[u] - s), 192'((u == 0) ? 34 : 36));
        end

        // Random start pulses and bases, checked cycle by cycle by the model.
        for (int i = 0; i < 32; i++) mem[i] = rand_row();
        for (int i = 0; i < 300; i++) begin
            start = ($urandom_range(0, 7) == 0);
            base  = 5'($urandom);
            tick();
        end
        start = 1'b0;
        repeat (60) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
